// File: rtl/uart_frame_arbiter.sv
// uart_frame_arbiter: round-robin arbiter that wraps one 16-bit channel sample
// into a 5-byte frame (header, id, hi, lo, checksum) for the UART TX FIFO.
module uart_frame_arbiter #(
   parameter int          NCH    = 4,
   parameter logic [7:0]  HEADER = 8'hAA
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NCH-1:0]     req,
   input  logic [NCH*16-1:0]  sample,
   output logic [NCH-1:0]     ack,
   input  logic               fifo_full,
   output logic [7:0]         w_data,
   output logic               wr_uart,
   output logic               busy,
   output logic [2:0]         grant_id
);
   typedef enum logic [2:0] {IDLE, HDR, ID, HI, LO, SUM} state_t;
   state_t         state_q;
   logic [2:0]     last_q, id_q, sel_d, cand;
   logic           found_d;
   logic [15:0]    hold_q;
   logic [NCH-1:0] ack_q;
   logic [7:0]     req_ext, sum;
   logic [127:0]   sample_ext;
   assign req_ext    = 8'(req);
   assign sample_ext = 128'(sample);
   // search starts one past the last grant and wraps back around to it
   always_comb begin
      found_d = 1'b0;
      sel_d   = last_q;
      cand    = '0;
      for (int k = 1; k <= NCH; k++) begin
         cand = 3'((int'(last_q) + k) % NCH);
         if (!found_d && req_ext[cand]) begin
            found_d = 1'b1;
            sel_d   = cand;
         end
      end
   end
   assign sum      = {5'b0, id_q} + hold_q[15:8] + hold_q[7:0];
   assign busy     = state_q != IDLE;
   assign wr_uart  = busy & ~fifo_full;
   assign ack      = ack_q;
   assign grant_id = id_q;
   assign w_data   = state_q == HDR ? HEADER :
                     state_q == ID  ? {5'b0, id_q} :
                     state_q == HI  ? hold_q[15:8] :
                     state_q == LO  ? hold_q[7:0] :
                     state_q == SUM ? sum : 8'h00;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         last_q  <= 3'(NCH - 1);
         id_q    <= '0;
         hold_q  <= '0;
         ack_q   <= '0;
      end else begin
         ack_q <= '0;
         if (state_q == IDLE) begin
            if (found_d) begin
               hold_q  <= sample_ext[{sel_d, 4'b0} +: 16];
               id_q    <= sel_d;
               last_q  <= sel_d;
               ack_q   <= NCH'(1) << sel_d;
               state_q <= HDR;
            end
         end else if (wr_uart) begin
            state_q <= state_q == SUM ? IDLE : state_t'(state_q + 3'd1);
         end
      end
   end
endmodule

// File: tb/tb_uart_frame_arbiter.sv
// tb_uart_frame_arbiter: directed stimulus with a byte/ack scoreboard drained
// by a monitor that samples on the falling clock edge.
module tb_uart_frame_arbiter;
   localparam int NCH = 4;
   logic               clk = 1'b0, reset = 1'b0, fifo_full = 1'b0;
   logic [NCH-1:0]     req = '0;
   logic [NCH*16-1:0]  sample = '0;
   logic [NCH-1:0]     ack;
   logic [7:0]         w_data;
   logic               wr_uart, busy;
   logic [2:0]         grant_id;
   int                 checks = 0, failures = 0;
   logic [7:0]         exp_bytes[$];
   int                 exp_acks[$];

   always #5 clk = ~clk;

   uart_frame_arbiter #(.NCH(NCH), .HEADER(8'hAA)) dut (
      .clk(clk), .reset(reset), .req(req), .sample(sample), .ack(ack),
      .fifo_full(fifo_full), .w_data(w_data), .wr_uart(wr_uart),
      .busy(busy), .grant_id(grant_id)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic frame(input int ch, input logic [15:0] s, input logic [7:0] cs);
      exp_bytes.push_back(8'hAA);
      exp_bytes.push_back(8'(ch));
      exp_bytes.push_back(s[15:8]);
      exp_bytes.push_back(s[7:0]);
      exp_bytes.push_back(cs);
      exp_acks.push_back(ch);
   endtask

   task automatic monitor();
      forever begin
         @(negedge clk);
         if (reset) begin
            if (wr_uart) begin
               if (exp_bytes.size() == 0) chk("unexpected_byte", {24'd0, w_data}, 32'hFFFF_FFFF);
               else chk("byte", {24'd0, w_data}, {24'd0, exp_bytes.pop_front()});
            end
            if (ack != 0) begin
               if (exp_acks.size() == 0) chk("unexpected_ack", 32'(ack), 0);
               else begin
                  int e;
                  e = exp_acks.pop_front();
                  chk("ack", 32'(ack), 32'(1 << e));
                  chk("grant_id", 32'(grant_id), 32'(e));
                  chk("ack_in_hdr", {24'd0, w_data}, 32'hAA);
               end
            end
         end
      end
   endtask

   task automatic check_reset_outputs(input string name);
      chk({name, "_ack"}, 32'(ack), 0);
      chk({name, "_wr"}, 32'(wr_uart), 0);
      chk({name, "_wdata"}, 32'(w_data), 0);
      chk({name, "_busy"}, 32'(busy), 0);
      chk({name, "_gid"}, 32'(grant_id), 0);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b0; req = '0; fifo_full = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while ((busy || req != 0 || exp_bytes.size() != 0) && n < 300) begin
         @(posedge clk); #1;
         req = req & ~ack;
         n++;
      end
      chk({name, "_timeout"}, 32'(n < 300), 1);
      chk({name, "_idle"}, 32'(busy), 0);
   endtask

   task automatic wait_byte_state(input logic [7:0] b, input string name);
      int n = 0;
      while (!(busy && w_data == b) && n < 100) begin
         @(posedge clk); #1;
         req = req & ~ack;
         n++;
      end
      chk({name, "_reach"}, 32'(n < 100), 1);
   endtask

   initial begin
      int nacks;
      fork monitor(); join_none
      repeat (2) @(posedge clk);
      #1 check_reset_outputs("por");
      reset = 1'b1;
      // single channel
      sample[32 +: 16] = 16'h1234;
      req = 4'b0100;
      frame(2, 16'h1234, 8'h48);
      wait_done("single");
      chk("gid_hold_idle", 32'(grant_id), 2);
      // simultaneous requests
      do_reset();
      sample = {16'h00FF, 16'h7F80, 16'hA0B0, 16'h0102};
      req = 4'hF;
      frame(0, 16'h0102, 8'h03);
      frame(1, 16'hA0B0, 8'h51);
      frame(2, 16'h7F80, 8'h01);
      frame(3, 16'h00FF, 8'h02);
      wait_done("simul");
      // backpressure while HI byte is current
      do_reset();
      sample[0 +: 16] = 16'h1234;
      req = 4'b0001;
      frame(0, 16'h1234, 8'h46);
      wait_byte_state(8'h12, "bp");
      fifo_full = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_wr_low", 32'(wr_uart), 0);
         if (i < 2) @(posedge clk);
      end
      @(posedge clk); #1;
      fifo_full = 1'b0;
      wait_done("bp");
      // checksum wrap
      sample[48 +: 16] = 16'hFFFF;
      req = 4'b1000;
      frame(3, 16'hFFFF, 8'h01);
      wait_done("wrap");
      // fairness
      do_reset();
      sample[16 +: 16] = 16'h1111;
      sample[48 +: 16] = 16'h3333;
      for (int i = 0; i < 3; i++) begin
         frame(1, 16'h1111, 8'h23);
         frame(3, 16'h3333, 8'h69);
      end
      req = 4'b1010;
      nacks = 0;
      for (int n = 0; n < 400 && nacks < 6; n++) begin
         @(posedge clk); #1;
         if (ack != 0) nacks++;
      end
      req = '0;
      chk("fair_acks", 32'(nacks), 6);
      wait_done("fair");
      // reset mid-frame during LO
      do_reset();
      sample[32 +: 16] = 16'h5678;
      req = 4'b0100;
      exp_bytes.push_back(8'hAA);
      exp_bytes.push_back(8'h02);
      exp_bytes.push_back(8'h56);
      exp_acks.push_back(2);
      wait_byte_state(8'h78, "midrst");
      reset = 1'b0;
      req = '0;
      #1 check_reset_outputs("midrst");
      chk("midrst_bytes_left", 32'(exp_bytes.size()), 0);
      @(posedge clk); #1;
      reset = 1'b1;
      req = 4'b0100;
      frame(2, 16'h5678, 8'hD0);
      wait_done("after_rst");
      chk("acks_left", 32'(exp_acks.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/uart_frame_arbiter.md
# uart_frame_arbiter

Shares the single UART transmit path (baud generator, TX FIFO and serialiser) among up to eight sample producers, such as parallel filter channels. It round-robin arbitrates between channels that hold a 16-bit sample ready. It wraps each granted sample in a fixed 5-byte frame and writes the frame byte-by-byte into the TX FIFO write port (`w_data`/`wr_uart`), honouring the FIFO full flag. It sits between the filter datapath and the UART TX top.

## Interface
- `NCH`, 4: number of requesting channels; legal range 1–8.
- `HEADER`, 8'hAA: frame start byte.
- `clk`  in  1  system clock (50 MHz), all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  NCH  per-channel sample-ready; held high until the matching `ack`.
- `sample`  in  NCH*16  channel i sample at bits [16i+15:16i]; stable while `req[i]` is high.
- `ack`  out  NCH  one-cycle pulse: sample of that channel captured.
- `fifo_full`  in  1  TX FIFO full flag.
- `w_data`  out  8  byte to TX FIFO.
- `wr_uart`  out  1  TX FIFO write strobe; one byte written per high cycle.
- `busy`  out  1  high whenever the state is not IDLE.
- `grant_id`  out  3  channel currently being framed; holds the last granted value in IDLE.

## Operation
- Frame layout, in order: `HEADER`, channel id (zero-extended to 8 bits), sample[15:8], sample[7:0], checksum.
- Checksum = (id + hi + lo) mod 256. The header is excluded.
- States: IDLE, HDR, ID, HI, LO, SUM.
- IDLE, with any `req` bit high:
  - Select a channel round-robin. The search starts at `last+1` (mod NCH) and wraps to `last`.
  - Latch the selected sample into a 16-bit holding register, latch its id, and update `last`.
  - Next state is HDR.
- IDLE, with no request: remain in IDLE.
- `last` resets to NCH-1, so channel 0 has first priority after reset.
- `ack[g]` is registered. It is high for exactly the first HDR cycle of each frame, one cycle after the grant decision. All other `ack` bits are 0.
- Byte states (HDR..SUM):
  - `wr_uart` = ~`fifo_full` (combinational).
  - `w_data` = the byte for the current state (combinational mux of registered values).
  - On a cycle with `wr_uart` high, advance to the next state; SUM advances to IDLE.
  - With `fifo_full` high, hold the state with `wr_uart` low. No byte is dropped or duplicated.
- Outside byte states: `wr_uart` = 0 and `w_data` = 8'h00.
- A channel that keeps `req` high after `ack` presents its next sample. It re-competes in the next IDLE cycle under round-robin.
- `req` bits for channels ≥ NCH do not exist. The id field is 3 bits wide internally.

## Timing
- Reset values:
  - state IDLE
  - `ack` = 0, `wr_uart` = 0, `w_data` = 0
  - `busy` = 0, `grant_id` = 0
  - `last` = NCH-1, holding register = 0
- Minimum frame cost is 6 cycles: 1 IDLE plus 5 byte cycles.
- Back-to-back frames produce one idle write gap between them.
- `req` is sampled only in IDLE. A `req` rising during a frame waits for the next IDLE.
- Simultaneous requests are resolved purely by the round-robin order described above.
- A `req` dropped before `ack` (protocol violation) is ignored if not yet granted. Once granted, the frame completes with the latched sample.
- `fifo_full` may toggle on any cycle. Each byte is written on the first cycle its state sees `fifo_full` = 0.
- Reset mid-frame:
  - Immediately forces IDLE and `wr_uart` = 0.
  - Bytes already written remain in the FIFO as a truncated frame. Receivers resynchronise on `HEADER`.
  - The pending channel receives no second `ack` for the aborted frame; it is re-arbitrated normally.

## Test plan
- **Single channel.** After reset, `req[2]`=1 with sample 0x1234 and `fifo_full`=0.
  - Required: `wr_uart` high on 5 consecutive cycles with bytes AA,02,12,34,48.
  - `ack[2]` is a single pulse in the AA cycle; `busy` returns to 0.
- **Simultaneous requests.** All four `req` high at once, each held until its `ack`.
  - Required: frames in channel order 0,1,2,3.
  - Ids and checksums are correct for each frame.
- **Backpressure.** `fifo_full`=1 for 3 cycles starting when the HI byte is current (sample 0x1234, ch0).
  - Required: `wr_uart`=0 for those 3 cycles, then byte 0x12 is written once.
  - The total byte sequence is unchanged: AA,00,12,34,46.
- **Checksum wrap.** ch3, sample 0xFFFF.
  - Required: bytes AA,03,FF,FF,01.
- **Fairness.** `req[1]` and `req[3]` held permanently high.
  - Required: grants alternate 1,3,1,3…; neither channel is served twice in a row.
- **Reset mid-frame.** Drive `reset` low during the LO state, then release it.
  - Required: `wr_uart` goes 0 asynchronously and all outputs take their reset values.
  - The next request produces a complete, correct frame starting with AA.
